cache_miss_controller: RTL and testbench



---
 rtl/cache_pkg.sv | 26 ++
 rtl/cache_miss_controller_if.sv | 25 ++
 rtl/cache_way_array.sv | 47 ++++
 rtl/cache_miss_controller.sv | 186 ++++++++++++++++++
 tb/tb_cache_miss_controller.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared constants, FSM state type and address helpers
// for the 2-way data cache miss controller.
package cache_pkg;

  localparam int ADDR_WIDTH   = 32;
  localparam int DATA_WIDTH   = 32;
  localparam int SET_WIDTH    = 3;
  localparam int TAG_WIDTH    = ADDR_WIDTH - SET_WIDTH - 2;
  localparam int CACHE_LENGTH = 2 ** SET_WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    FILL    = 2'd2,
    WR_THRU = 2'd3
  } state_t;

  function automatic logic [SET_WIDTH-1:0] addr_set(input logic [ADDR_WIDTH-1:0] addr);
    return addr[SET_WIDTH+1:2];
  endfunction

  function automatic logic [TAG_WIDTH-1:0] addr_tag(input logic [ADDR_WIDTH-1:0] addr);
    return addr[ADDR_WIDTH-1:ADDR_WIDTH-TAG_WIDTH];
  endfunction

endpackage

// File: rtl/cache_miss_controller_if.sv
// rtl/cache_miss_controller_if.sv - data memory bus between the cache
// controller (master) and data memory (slave).
interface cache_miss_controller_if #(
  parameter int ADDR_WIDTH = cache_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = cache_pkg::DATA_WIDTH
);

  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic                  mem_ack_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );

endinterface

// File: rtl/cache_way_array.sv
// rtl/cache_way_array.sv - one cache way: valid/tag/data per set with
// asynchronous read, synchronous write and reset-cleared valid bits.
module cache_way_array
  import cache_pkg::*;
#(
  parameter int SW  = SET_WIDTH,
  parameter int TW  = TAG_WIDTH,
  parameter int DW  = DATA_WIDTH,
  parameter int LEN = CACHE_LENGTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [SW-1:0] rd_set,
  output logic          rd_valid,
  output logic [TW-1:0] rd_tag,
  output logic [DW-1:0] rd_data,
  input  logic          wr_en,
  input  logic [SW-1:0] wr_set,
  input  logic [TW-1:0] wr_tag,
  input  logic [DW-1:0] wr_data
);

  logic [LEN-1:0] valid_q;
  logic [TW-1:0]  tag_q  [LEN];
  logic [DW-1:0]  data_q [LEN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_set] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; a clear valid bit masks them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_set]  <= wr_tag;
      data_q[wr_set] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_set];
  assign rd_tag   = tag_q[rd_set];
  assign rd_data  = data_q[rd_set];

endmodule

// File: rtl/cache_miss_controller.sv
// rtl/cache_miss_controller.sv - 2-way set-associative data cache: load hits
// answered from the arrays, load misses refilled, all stores written through.
module cache_miss_controller #(
  parameter int ADDR_WIDTH   = cache_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH   = cache_pkg::DATA_WIDTH,
  parameter int SET_WIDTH    = cache_pkg::SET_WIDTH,
  parameter int TAG_WIDTH    = cache_pkg::TAG_WIDTH,
  parameter int CACHE_LENGTH = cache_pkg::CACHE_LENGTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cpu_req_i,
  input  logic                    cpu_we_i,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr_i,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata_i,
  output logic [DATA_WIDTH-1:0]   cpu_rdata_o,
  output logic                    cpu_stall_o,
  output logic                    hit_o,
  cache_miss_controller_if.master mem
);

  import cache_pkg::*;

  state_t state_q, state_d;

  logic [CACHE_LENGTH-1:0] lru_q;
  logic [DATA_WIDTH-1:0]   fill_q;
  logic                    req_q;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;

  logic [SET_WIDTH-1:0]  set;
  logic [TAG_WIDTH-1:0]  tag;
  logic                  v0, v1;
  logic [TAG_WIDTH-1:0]  t0, t1;
  logic [DATA_WIDTH-1:0] d0, d1;
  logic                  hit0, hit1, hit_any;
  logic                  victim;
  logic                  way_we0, way_we1;
  logic [DATA_WIDTH-1:0] way_wdata;
  logic                  lru_we, lru_val;
  logic                  start_mem;
  logic                  unused_addr_lsb;

  assign set             = addr_set(cpu_addr_i);
  assign tag             = addr_tag(cpu_addr_i);
  assign unused_addr_lsb = ^cpu_addr_i[1:0];

  cache_way_array u_way0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_set   (set),
    .rd_valid (v0),
    .rd_tag   (t0),
    .rd_data  (d0),
    .wr_en    (way_we0),
    .wr_set   (set),
    .wr_tag   (tag),
    .wr_data  (way_wdata)
  );

  cache_way_array u_way1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_set   (set),
    .rd_valid (v1),
    .rd_tag   (t1),
    .rd_data  (d1),
    .wr_en    (way_we1),
    .wr_set   (set),
    .wr_tag   (tag),
    .wr_data  (way_wdata)
  );

  assign hit0    = v0 & (t0 == tag);
  assign hit1    = v1 & (t1 == tag);
  assign hit_any = hit0 | hit1;

  // Empty ways are filled before LRU replacement kicks in.
  assign victim = !v0 ? 1'b0 : (!v1 ? 1'b1 : lru_q[set]);

  // Only a store or a load miss in IDLE launches a memory transaction.
  assign start_mem = (state_q == IDLE) && cpu_req_i && (cpu_we_i || !hit_any);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cpu_stall_o = 1'b0;
    hit_o       = 1'b0;
    cpu_rdata_o = hit1 ? d1 : d0;
    way_we0     = 1'b0;
    way_we1     = 1'b0;
    way_wdata   = cpu_wdata_i;
    lru_we      = 1'b0;
    lru_val     = 1'b0;
    case (state_q)
      IDLE: begin
        hit_o = cpu_req_i & hit_any;
        if (cpu_req_i) begin
          if (cpu_we_i) begin
            cpu_stall_o = 1'b1;
            state_d     = WR_THRU;
            way_we0     = hit0;
            way_we1     = hit1;
            lru_we      = hit_any;
            lru_val     = hit0;
          end else if (hit_any) begin
            lru_we  = 1'b1;
            lru_val = hit0;
          end else begin
            cpu_stall_o = 1'b1;
            state_d     = RD_MISS;
          end
        end
      end
      RD_MISS: begin
        cpu_stall_o = 1'b1;
        if (mem.mem_ack_i) begin
          state_d = FILL;
        end
      end
      FILL: begin
        cpu_rdata_o = fill_q;
        way_wdata   = fill_q;
        way_we0     = !victim;
        way_we1     = victim;
        lru_we      = 1'b1;
        lru_val     = !victim;
        state_d     = IDLE;
      end
      WR_THRU: begin
        cpu_stall_o = !mem.mem_ack_i;
        if (mem.mem_ack_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lru_q <= '0;
    end else if (lru_we) begin
      lru_q[set] <= lru_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      fill_q  <= '0;
    end else begin
      if (start_mem) begin
        req_q  <= 1'b1;
        we_q   <= cpu_we_i;
        addr_q <= {cpu_addr_i[ADDR_WIDTH-1:2], 2'b00};
        if (cpu_we_i) begin
          wdata_q <= cpu_wdata_i;
        end
      end else if (req_q && mem.mem_ack_i) begin
        req_q <= 1'b0;
        if (state_q == RD_MISS) begin
          fill_q <= mem.mem_rdata_i;
        end
      end
    end
  end

  assign mem.mem_req_o   = req_q;
  assign mem.mem_we_o    = we_q;
  assign mem.mem_addr_o  = addr_q;
  assign mem.mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_cache_miss_controller.sv
// tb/tb_cache_miss_controller.sv - scoreboard bench for cache_miss_controller
// with a behavioural data memory of programmable ack latency.
module tb_cache_miss_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        hit;

  cache_miss_controller_if mem_if ();

  cache_miss_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_req_i   (cpu_req),
    .cpu_we_i    (cpu_we),
    .cpu_addr_i  (cpu_addr),
    .cpu_wdata_i (cpu_wdata),
    .cpu_rdata_o (cpu_rdata),
    .cpu_stall_o (cpu_stall),
    .hit_o       (hit),
    .mem         (mem_if)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] exp_q[$];
  logic [31:0] mem_model[logic [31:0]];
  int          mem_delay = 1;
  int          wait_cnt = 0;
  int          mem_txns = 0;
  logic        spurious_ack = 1'b0;
  logic [31:0] last_addr = '0;
  logic [31:0] last_wdata = '0;
  logic        last_we = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : 32'h0;
  endfunction

  // Data memory: acks mem_delay cycles after seeing a request.
  initial begin
    mem_if.mem_ack_i   = 1'b0;
    mem_if.mem_rdata_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_if.mem_req_o) begin
        if (wait_cnt >= mem_delay) begin
          mem_if.mem_ack_i = 1'b1;
          last_addr = mem_if.mem_addr_o;
          last_we   = mem_if.mem_we_o;
          last_wdata = mem_if.mem_wdata_o;
          mem_txns++;
          if (mem_if.mem_we_o) mem_model[mem_if.mem_addr_o] = mem_if.mem_wdata_o;
          else mem_if.mem_rdata_i = model_rd(mem_if.mem_addr_o);
          wait_cnt = 0;
        end else begin
          mem_if.mem_ack_i = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_if.mem_ack_i = spurious_ack;
        wait_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && dut.hit0 && dut.hit1) check("double_hit", 32'd1, 32'd0);
  end

  task automatic cpu_access(input string tag, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_data,
                            input logic exp_hit, input int exp_stalls);
    int   stalls;
    int   t0;
    logic done;
    stalls = 0;
    done = 1'b0;
    t0 = mem_txns;
    @(posedge clk);
    #1;
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = addr;
    cpu_wdata = wdata;
    if (!we) exp_q.push_back(exp_data);
    @(negedge clk);
    check({tag, "_hit"}, {31'd0, hit}, {31'd0, exp_hit});
    for (int c = 0; c < 100; c++) begin
      if (c > 0) @(negedge clk);
      if (!cpu_stall) begin
        done = 1'b1;
        if (!we) check({tag, "_rdata"}, cpu_rdata, exp_q.pop_front());
        break;
      end
      stalls++;
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_stalls"}, stalls, exp_stalls);
    check({tag, "_txns"}, mem_txns - t0, (we || !exp_hit) ? 32'd1 : 32'd0);
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #12;
    check("rst_stall", {31'd0, cpu_stall}, 32'd0);
    check("rst_hit", {31'd0, hit}, 32'd0);
    check("rst_mem_req", {31'd0, mem_if.mem_req_o}, 32'd0);
    check("rst_mem_we", {31'd0, mem_if.mem_we_o}, 32'd0);
    check("rst_mem_addr", mem_if.mem_addr_o, 32'd0);
    check("rst_mem_wdata", mem_if.mem_wdata_o, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic refill with a 2-cycle memory wait, then a zero-latency hit.
    mem_model[32'h40] = 32'hDEAD_BEEF;
    mem_delay = 2;
    cpu_access("ld40_miss", 1'b0, 32'h40, '0, 32'hDEAD_BEEF, 1'b0, 4);
    check("ld40_addr", last_addr, 32'h40);
    check("ld40_we", {31'd0, last_we}, 32'd0);
    cpu_access("ld40_hit", 1'b0, 32'h40, '0, 32'hDEAD_BEEF, 1'b1, 0);

    // Three tags into set 0: LRU replacement.
    apply_reset();
    mem_delay = 1;
    mem_model[32'h040] = 32'd1;
    mem_model[32'h440] = 32'd2;
    mem_model[32'h840] = 32'd3;
    cpu_access("s0_a", 1'b0, 32'h040, '0, 32'd1, 1'b0, 3);
    cpu_access("s0_b", 1'b0, 32'h440, '0, 32'd2, 1'b0, 3);
    cpu_access("s0_c", 1'b0, 32'h840, '0, 32'd3, 1'b0, 3);
    cpu_access("s0_b_hit", 1'b0, 32'h440, '0, 32'd2, 1'b1, 0);
    cpu_access("s0_a_miss", 1'b0, 32'h040, '0, 32'd1, 1'b0, 3);
    cpu_access("s0_b_hit2", 1'b0, 32'h440, '0, 32'd2, 1'b1, 0);

    // Store hit: write-through plus array update.
    cpu_access("st40", 1'b1, 32'h40, 32'h1234_5678, '0, 1'b1, 2);
    check("st40_we", {31'd0, last_we}, 32'd1);
    check("st40_addr", last_addr, 32'h40);
    check("st40_wdata", last_wdata, 32'h1234_5678);
    cpu_access("ld40_after_st", 1'b0, 32'h40, '0, 32'h1234_5678, 1'b1, 0);

    // Store miss does not allocate.
    cpu_access("st80", 1'b1, 32'h82, 32'hA5A5_0080, '0, 1'b0, 2);
    check("st80_addr", last_addr, 32'h80);
    cpu_access("ld80_miss", 1'b0, 32'h80, '0, 32'hA5A5_0080, 1'b0, 3);

    // Ack in the same cycle the request rises.
    mem_delay = 0;
    mem_model[32'hC0] = 32'h0C0C_0C0C;
    cpu_access("ldC0_fast", 1'b0, 32'hC0, '0, 32'h0C0C_0C0C, 1'b0, 2);
    cpu_access("stC4_fast", 1'b1, 32'hC4, 32'h0000_0011, '0, 1'b0, 1);
    cpu_access("ldC4_fast", 1'b0, 32'hC4, '0, 32'h0000_0011, 1'b0, 2);

    // Spurious ack while idle.
    @(posedge clk);
    #2;
    spurious_ack = 1'b1;
    repeat (2) @(negedge clk);
    check("spur_req", {31'd0, mem_if.mem_req_o}, 32'd0);
    check("spur_stall", {31'd0, cpu_stall}, 32'd0);
    spurious_ack = 1'b0;
    cpu_access("ldC0_hit", 1'b0, 32'hC0, '0, 32'h0C0C_0C0C, 1'b1, 0);

    // Reset in the middle of a refill.
    mem_delay = 10;
    @(posedge clk);
    #1;
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 32'h100;
    exp_q.push_back(model_rd(32'h100));
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_if.mem_req_o) break;
    end
    check("abort_req_seen", {31'd0, mem_if.mem_req_o}, 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_mem_req", {31'd0, mem_if.mem_req_o}, 32'd0);
    cpu_req = 1'b0;
    #1;
    check("abort_stall", {31'd0, cpu_stall}, 32'd0);
    void'(exp_q.pop_front());
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_delay = 1;
    cpu_access("ld40_post_rst", 1'b0, 32'h40, '0, 32'h1234_5678, 1'b0, 3);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
